// File: rtl/product_accumulator_if.sv
// Stream bundle between a product source, the product accumulator and the
// result consumer. Signal names follow the accumulator's port list.
interface product_accumulator_if #(
  parameter int ACC_WIDTH = 72
);
  logic                 I_STB;
  logic                 I_ACK;
  logic [63:0]          I_DAT;
  logic                 I_FLUSH;
  logic                 O_STB;
  logic                 O_ACK;
  logic [ACC_WIDTH-1:0] O_DAT;
  logic [7:0]           O_CNT;
  logic                 O_OVF;

  // Accumulator view: consumes products, produces block sums.
  modport slave (
    input  I_STB, I_DAT, I_FLUSH, O_ACK,
    output I_ACK, O_STB, O_DAT, O_CNT, O_OVF
  );

  // Environment view: drives products and accepts results.
  modport master (
    output I_STB, I_DAT, I_FLUSH, O_ACK,
    input  I_ACK, O_STB, O_DAT, O_CNT, O_OVF
  );
endinterface

// File: rtl/product_accumulator.sv
// Product accumulator: sums blocks of up to TERMS unsigned 64-bit products
// into an ACC_WIDTH-bit sum with a sticky wrap flag and a term count.
// A block closes after TERMS products or early on I_FLUSH; the result is
// then held until the consumer acknowledges it.
module product_accumulator #(
  parameter int TERMS     = 8,
  parameter int ACC_WIDTH = 72
) (
  input  logic                  CLK,
  input  logic                  RST,
  product_accumulator_if.slave  bus
);

  generate
    if (TERMS < 1 || TERMS > 255) begin : g_bad_terms
      $error("product_accumulator: TERMS must be in 1..255");
    end
    if (ACC_WIDTH < 64) begin : g_bad_width
      $error("product_accumulator: ACC_WIDTH must be >= 64");
    end
  endgenerate

  localparam logic [0:0] ST_ACCUM  = 1'b0;
  localparam logic [0:0] ST_OUTPUT = 1'b1;
  localparam logic [7:0] TERMS_L   = TERMS[7:0];

  logic [0:0]           state_r;
  logic [ACC_WIDTH-1:0] acc_r;
  logic [7:0]           cnt_r;
  logic                 ovf_r;
  logic [ACC_WIDTH-1:0] o_dat_r;
  logic [7:0]           o_cnt_r;
  logic                 o_ovf_r;

  logic                 in_xfer_s;
  logic [ACC_WIDTH:0]   dat_ext_s;
  logic [ACC_WIDTH:0]   sum_s;
  logic [7:0]           cnt_inc_s;
  logic                 close_s;
  logic [ACC_WIDTH-1:0] fin_sum_s;
  logic [7:0]           fin_cnt_s;
  logic                 fin_ovf_s;

  // Handshake flags come from the state register alone, so there is no
  // combinational path from I_STB or O_ACK to either of them.
  assign bus.I_ACK = (state_r == ST_ACCUM);
  assign bus.O_STB = (state_r == ST_OUTPUT);
  assign bus.O_DAT = o_dat_r;
  assign bus.O_CNT = o_cnt_r;
  assign bus.O_OVF = o_ovf_r;

  // Next-sum datapath and block-close decision for the current cycle.
  always_comb begin
    dat_ext_s       = '0;
    dat_ext_s[63:0] = bus.I_DAT;
    in_xfer_s       = bus.I_STB & (state_r == ST_ACCUM);
    sum_s           = {1'b0, acc_r} + dat_ext_s;
    cnt_inc_s       = cnt_r + 8'd1;
    fin_sum_s       = acc_r;
    fin_cnt_s       = cnt_r;
    fin_ovf_s       = ovf_r;
    close_s         = 1'b0;
    if (in_xfer_s) begin
      // The term arriving this edge belongs to the block it may close.
      fin_sum_s = sum_s[ACC_WIDTH-1:0];
      fin_cnt_s = cnt_inc_s;
      fin_ovf_s = ovf_r | sum_s[ACC_WIDTH];
    end else begin
      fin_sum_s = acc_r;
      fin_cnt_s = cnt_r;
      fin_ovf_s = ovf_r;
    end
    if (state_r == ST_ACCUM) begin
      // A flush only closes a non-empty block; empty flushes are dropped.
      close_s = (in_xfer_s && (cnt_inc_s == TERMS_L)) ||
                (bus.I_FLUSH && ((cnt_r != 8'd0) || in_xfer_s));
    end else begin
      close_s = 1'b0;
    end
  end

  // State, running sum and held result registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= ST_ACCUM;
      acc_r   <= '0;
      cnt_r   <= 8'd0;
      ovf_r   <= 1'b0;
      o_dat_r <= '0;
      o_cnt_r <= 8'd0;
      o_ovf_r <= 1'b0;
    end else begin
      case (state_r)
        ST_ACCUM: begin
          if (close_s) begin
            o_dat_r <= fin_sum_s;
            o_cnt_r <= fin_cnt_s;
            o_ovf_r <= fin_ovf_s;
            acc_r   <= '0;
            cnt_r   <= 8'd0;
            ovf_r   <= 1'b0;
            state_r <= ST_OUTPUT;
          end else if (in_xfer_s) begin
            acc_r <= fin_sum_s;
            cnt_r <= fin_cnt_s;
            ovf_r <= fin_ovf_s;
          end else begin
            acc_r <= acc_r;
          end
        end
        ST_OUTPUT: begin
          if (bus.O_ACK) begin
            state_r <= ST_ACCUM;
          end else begin
            state_r <= ST_OUTPUT;
          end
        end
        default: begin
          state_r <= ST_ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: one DUT with a 72-bit sum and one
// with a 64-bit sum for wrap behaviour, both with TERMS=4.
module tb_product_accumulator;

  logic CLK;
  logic RST;
  int   total;
  int   bad;

  product_accumulator_if #(.ACC_WIDTH(72)) bus_a ();
  product_accumulator_if #(.ACC_WIDTH(64)) bus_b ();

  product_accumulator #(.TERMS(4), .ACC_WIDTH(72)) dut_a (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_a)
  );

  product_accumulator #(.TERMS(4), .ACC_WIDTH(64)) dut_b (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Present one product to dut_a (optionally with flush) until it transfers.
  task automatic send_a(input logic [63:0] d, input logic fl);
    int n;
    n = 0;
    bus_a.I_STB   = 1'b1;
    bus_a.I_DAT   = d;
    bus_a.I_FLUSH = fl;
    while (bus_a.I_ACK !== 1'b1 && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL send_a_timeout: I_ACK=%b required 1", bus_a.I_ACK);
    end
    @(posedge CLK); #1;
    bus_a.I_STB   = 1'b0;
    bus_a.I_FLUSH = 1'b0;
  endtask

  task automatic send_b(input logic [63:0] d, input logic fl);
    int n;
    n = 0;
    bus_b.I_STB   = 1'b1;
    bus_b.I_DAT   = d;
    bus_b.I_FLUSH = fl;
    while (bus_b.I_ACK !== 1'b1 && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL send_b_timeout: I_ACK=%b required 1", bus_b.I_ACK);
    end
    @(posedge CLK); #1;
    bus_b.I_STB   = 1'b0;
    bus_b.I_FLUSH = 1'b0;
  endtask

  task automatic ack_a();
    bus_a.O_ACK = 1'b1;
    @(posedge CLK); #1;
    bus_a.O_ACK = 1'b0;
  endtask

  task automatic ack_b();
    bus_b.O_ACK = 1'b1;
    @(posedge CLK); #1;
    bus_b.O_ACK = 1'b0;
  endtask

  task automatic flush_a();
    bus_a.I_FLUSH = 1'b1;
    @(posedge CLK); #1;
    bus_a.I_FLUSH = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (bus_a.I_ACK !== 1'b1 || bus_a.O_STB !== 1'b0) begin
      bad++; $display("FAIL reset_hs: ack=%b stb=%b required 1 0", bus_a.I_ACK, bus_a.O_STB);
    end
    total++;
    if (bus_a.O_DAT !== 72'd0 || bus_a.O_CNT !== 8'd0 || bus_a.O_OVF !== 1'b0) begin
      bad++; $display("FAIL reset_out: dat=%0d cnt=%0d ovf=%b required 0 0 0",
                      bus_a.O_DAT, bus_a.O_CNT, bus_a.O_OVF);
    end
    total++;
    if (bus_b.I_ACK !== 1'b1 || bus_b.O_STB !== 1'b0 || bus_b.O_DAT !== 64'd0) begin
      bad++; $display("FAIL reset_b: ack=%b stb=%b dat=%0d required 1 0 0",
                      bus_b.I_ACK, bus_b.O_STB, bus_b.O_DAT);
    end
  endtask

  task automatic test_block();
    send_a(64'd1, 1'b0);
    send_a(64'd2, 1'b0);
    send_a(64'd3, 1'b0);
    total++;
    if (bus_a.O_STB !== 1'b0) begin
      bad++; $display("FAIL block_early: O_STB=%b required 0", bus_a.O_STB);
    end
    send_a(64'd4, 1'b0);
    total++;
    if (bus_a.O_STB !== 1'b1 || bus_a.I_ACK !== 1'b0) begin
      bad++; $display("FAIL block_hs: stb=%b ack=%b required 1 0", bus_a.O_STB, bus_a.I_ACK);
    end
    total++;
    if (bus_a.O_DAT !== 72'd10 || bus_a.O_CNT !== 8'd4 || bus_a.O_OVF !== 1'b0) begin
      bad++; $display("FAIL block_sum: dat=%0d cnt=%0d ovf=%b required 10 4 0",
                      bus_a.O_DAT, bus_a.O_CNT, bus_a.O_OVF);
    end
  endtask

  task automatic test_backpressure();
    bus_a.I_STB = 1'b1;
    bus_a.I_DAT = 64'd7;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      total++;
      if (bus_a.O_STB !== 1'b1 || bus_a.I_ACK !== 1'b0 || bus_a.O_DAT !== 72'd10) begin
        bad++; $display("FAIL hold_%0d: stb=%b ack=%b dat=%0d required 1 0 10",
                        i, bus_a.O_STB, bus_a.I_ACK, bus_a.O_DAT);
      end
    end
    ack_a();
    total++;
    if (bus_a.O_STB !== 1'b0 || bus_a.I_ACK !== 1'b1) begin
      bad++; $display("FAIL release: stb=%b ack=%b required 0 1", bus_a.O_STB, bus_a.I_ACK);
    end
    @(posedge CLK); #1;
    bus_a.I_STB = 1'b0;
    flush_a();
    total++;
    if (bus_a.O_STB !== 1'b1 || bus_a.O_DAT !== 72'd7 || bus_a.O_CNT !== 8'd1) begin
      bad++; $display("FAIL held_term: stb=%b dat=%0d cnt=%0d required 1 7 1",
                      bus_a.O_STB, bus_a.O_DAT, bus_a.O_CNT);
    end
    ack_a();
  endtask

  task automatic test_flush();
    send_a(64'd5, 1'b0);
    send_a(64'd6, 1'b0);
    flush_a();
    total++;
    if (bus_a.O_STB !== 1'b1 || bus_a.O_DAT !== 72'd11 || bus_a.O_CNT !== 8'd2 ||
        bus_a.O_OVF !== 1'b0) begin
      bad++; $display("FAIL flush_sum: stb=%b dat=%0d cnt=%0d ovf=%b required 1 11 2 0",
                      bus_a.O_STB, bus_a.O_DAT, bus_a.O_CNT, bus_a.O_OVF);
    end
    flush_a();
    total++;
    if (bus_a.O_STB !== 1'b1 || bus_a.O_DAT !== 72'd11 || bus_a.O_CNT !== 8'd2) begin
      bad++; $display("FAIL flush_in_output: stb=%b dat=%0d cnt=%0d required 1 11 2",
                      bus_a.O_STB, bus_a.O_DAT, bus_a.O_CNT);
    end
    ack_a();
    flush_a();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus_a.O_STB !== 1'b0 || bus_a.I_ACK !== 1'b1) begin
        bad++; $display("FAIL empty_flush_%0d: stb=%b ack=%b required 0 1",
                        i, bus_a.O_STB, bus_a.I_ACK);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_overflow();
    logic [63:0] ones;
    ones = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 4; i++) send_b(ones, 1'b0);
    total++;
    if (bus_b.O_STB !== 1'b1 || bus_b.O_DAT !== 64'hFFFF_FFFF_FFFF_FFFC ||
        bus_b.O_OVF !== 1'b1 || bus_b.O_CNT !== 8'd4) begin
      bad++; $display("FAIL ovf_sum: stb=%b dat=%h ovf=%b cnt=%0d required 1 fffffffffffffffc 1 4",
                      bus_b.O_STB, bus_b.O_DAT, bus_b.O_OVF, bus_b.O_CNT);
    end
    ack_b();
    send_b(64'd1, 1'b0);
    send_b(64'd2, 1'b1);
    total++;
    if (bus_b.O_STB !== 1'b1 || bus_b.O_DAT !== 64'd3 || bus_b.O_OVF !== 1'b0 ||
        bus_b.O_CNT !== 8'd2) begin
      bad++; $display("FAIL ovf_clear: stb=%b dat=%0d ovf=%b cnt=%0d required 1 3 0 2",
                      bus_b.O_STB, bus_b.O_DAT, bus_b.O_OVF, bus_b.O_CNT);
    end
    ack_b();
  endtask

  task automatic test_flush_same_edge();
    send_a(64'd1, 1'b0);
    send_a(64'd1, 1'b0);
    send_a(64'd1, 1'b1);
    total++;
    if (bus_a.O_STB !== 1'b1 || bus_a.O_DAT !== 72'd3 || bus_a.O_CNT !== 8'd3) begin
      bad++; $display("FAIL flush_same_edge: stb=%b dat=%0d cnt=%0d required 1 3 3",
                      bus_a.O_STB, bus_a.O_DAT, bus_a.O_CNT);
    end
    ack_a();
  endtask

  task automatic test_reset_mid();
    send_a(64'd9, 1'b0);
    send_a(64'd9, 1'b0);
    #2 RST = 1'b0;
    #1;
    total++;
    if (bus_a.I_ACK !== 1'b1 || bus_a.O_STB !== 1'b0 || bus_a.O_DAT !== 72'd0 ||
        bus_a.O_CNT !== 8'd0) begin
      bad++; $display("FAIL reset_mid: ack=%b stb=%b dat=%0d cnt=%0d required 1 0 0 0",
                      bus_a.I_ACK, bus_a.O_STB, bus_a.O_DAT, bus_a.O_CNT);
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    send_a(64'd2, 1'b0);
    send_a(64'd3, 1'b1);
    total++;
    if (bus_a.O_STB !== 1'b1 || bus_a.O_DAT !== 72'd5 || bus_a.O_CNT !== 8'd2) begin
      bad++; $display("FAIL post_reset_sum: stb=%b dat=%0d cnt=%0d required 1 5 2",
                      bus_a.O_STB, bus_a.O_DAT, bus_a.O_CNT);
    end
    #2 RST = 1'b0;
    #1;
    total++;
    if (bus_a.I_ACK !== 1'b1 || bus_a.O_STB !== 1'b0 || bus_a.O_DAT !== 72'd0 ||
        bus_a.O_CNT !== 8'd0 || bus_a.O_OVF !== 1'b0) begin
      bad++; $display("FAIL reset_output: ack=%b stb=%b dat=%0d cnt=%0d ovf=%b required 1 0 0 0 0",
                      bus_a.I_ACK, bus_a.O_STB, bus_a.O_DAT, bus_a.O_CNT, bus_a.O_OVF);
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    for (int i = 0; i < 4; i++) send_a(64'd1, 1'b0);
    total++;
    if (bus_a.O_STB !== 1'b1 || bus_a.O_DAT !== 72'd4 || bus_a.O_CNT !== 8'd4) begin
      bad++; $display("FAIL after_output_reset: stb=%b dat=%0d cnt=%0d required 1 4 4",
                      bus_a.O_STB, bus_a.O_DAT, bus_a.O_CNT);
    end
    ack_a();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RST   = 1'b0;
    bus_a.I_STB = 1'b0; bus_a.I_DAT = 64'd0; bus_a.I_FLUSH = 1'b0; bus_a.O_ACK = 1'b0;
    bus_b.I_STB = 1'b0; bus_b.I_DAT = 64'd0; bus_b.I_FLUSH = 1'b0; bus_b.O_ACK = 1'b0;
    #12;
    test_reset();
    #10 RST = 1'b1;
    @(posedge CLK); #1;
    test_block();
    test_backpressure();
    test_flush();
    test_overflow();
    test_flush_same_edge();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
